// File: rtl/xor_parity_acc.sv
// Frame parity accumulator: XOR-reduces each input word and accumulates parity
// over a frame of up to FRAME_LEN words, reporting one result per frame.
module xor_parity_acc #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int ODD       = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_parity,
    output logic [$clog2(FRAME_LEN+1)-1:0] out_words
);

    localparam int            CW       = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);
    localparam logic          ODD_BIT  = (ODD != 0);

    typedef enum logic {
        ACC,
        DONE
    } state_t;

    state_t        state;
    logic          acc;
    logic [CW-1:0] cnt;
    logic          word_par;
    logic          accept;
    logic          closing;

    assign word_par = ^in_data;
    assign in_ready = !rst && (state == ACC);
    assign accept   = in_valid && in_ready;
    // The frame closes on an explicit last word or when the word budget is used up.
    assign closing  = accept && (in_last || (cnt == LAST_CNT));

    // NOTE: every register is updated with <= so all of them see pre-edge values,
    // and every one of them (result fields included) is cleared by reset so a
    // discarded frame leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACC;
            acc        <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_parity <= 1'b0;
            out_words  <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (closing) begin
                        out_parity <= acc ^ word_par ^ ODD_BIT;
                        out_words  <= cnt + 1'b1;
                        out_valid  <= 1'b1;
                        acc        <= 1'b0;
                        cnt        <= '0;
                        state      <= DONE;
                    end else if (accept) begin
                        acc <= acc ^ word_par;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Result fields hold until the consumer takes them; no input bypass.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACC;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_parity_acc.sv
// Bench for xor_parity_acc: three instances (even, odd, FRAME_LEN=1) on shared
// stimulus, each checked every cycle against a word-counting reference model.
module tb_xor_parity_acc;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       rdy0, rdy1, rdy2;
    logic       vld0, vld1, vld2;
    logic       par0, par1, par2;
    logic [2:0] ow0, ow1;
    logic [0:0] ow2;

    int n_cmp = 0;
    int n_bad = 0;
    bit live  = 1'b0;

    // Reference model state, one slot per instance.
    int fl[3]    = '{4, 4, 1};
    int odd_p[3] = '{0, 1, 0};
    bit m_pend[3];
    bit m_par[3];
    int m_words[3];
    int m_n[3];
    int m_ones[3];

    always #5 clk = ~clk;

    xor_parity_acc #(.WIDTH(8), .FRAME_LEN(4), .ODD(0)) u_even (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .in_last(in_last), .out_valid(vld0), .out_ready(out_ready), .out_parity(par0),
        .out_words(ow0)
    );

    xor_parity_acc #(.WIDTH(8), .FRAME_LEN(4), .ODD(1)) u_odd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .in_last(in_last), .out_valid(vld1), .out_ready(out_ready), .out_parity(par1),
        .out_words(ow1)
    );

    xor_parity_acc #(.WIDTH(8), .FRAME_LEN(1), .ODD(0)) u_single (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
        .in_last(in_last), .out_valid(vld2), .out_ready(out_ready), .out_parity(par2),
        .out_words(ow2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready(input int i);
        return !rst && !m_pend[i];
    endfunction

    // Compare all instances against the model.
    task automatic compare();
        logic       a_rdy[3];
        logic       a_vld[3];
        logic       a_par[3];
        logic [2:0] a_ow[3];
        a_rdy = '{rdy0, rdy1, rdy2};
        a_vld = '{vld0, vld1, vld2};
        a_par = '{par0, par1, par2};
        a_ow  = '{ow0, ow1, {2'b00, ow2}};
        for (int i = 0; i < 3; i++) begin
            check($sformatf("in_ready[%0d]", i), 32'(a_rdy[i]), 32'(exp_ready(i)));
            check($sformatf("out_valid[%0d]", i), 32'(a_vld[i]), 32'(m_pend[i]));
            if (m_pend[i]) begin
                check($sformatf("out_parity[%0d]", i), 32'(a_par[i]), 32'(m_par[i]));
                check($sformatf("out_words[%0d]", i), 32'(a_ow[i]), 32'(m_words[i]));
            end
        end
    endtask

    // Model: count words and set bits of the open frame; parity is the ones count mod 2.
    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_pend[i] = 1'b0; m_n[i] = 0; m_ones[i] = 0;
            end else if (m_pend[i]) begin
                if (out_ready) m_pend[i] = 1'b0;
            end else if (in_valid) begin
                m_n[i]++;
                m_ones[i] += $countones(in_data);
                if (in_last || m_n[i] == fl[i]) begin
                    m_pend[i]  = 1'b1;
                    m_par[i]   = ((m_ones[i] % 2) != odd_p[i]);
                    m_words[i] = m_n[i];
                    m_n[i]     = 0;
                    m_ones[i]  = 0;
                end
            end
        end
    endtask

    // One clock: inputs already driven after the falling edge.
    task automatic cycle();
        #1;
        if (live) compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!exp_ready(0)) begin
            cycle();
            n++;
            if (n > 50) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: got no in_ready, expected in_ready within 50 cycles");
                break;
            end
        end
        cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        model_update();
        @(negedge clk);
        live = 1'b1;
        cycle();
        #1;
        check("reset out_valid", 32'(vld0), 0);
        check("reset out_parity", 32'(par0), 0);
        check("reset out_words", 32'(ow0), 0);
        check("reset in_ready", 32'(rdy0), 0);
        rst = 1'b0;
        cycle();

        // Full frame, back-to-back: even parity 0, odd parity 1, 4 words.
        send(8'h01, 0); in_valid = 1'b1; send(8'h03, 0); send(8'h00, 0); send(8'h80, 0);
        check("full even parity", 32'(par0), 0);
        check("full odd parity", 32'(par1), 1);
        check("full words", 32'(ow0), 4);
        check("full in_ready low", 32'(rdy0), 0);
        cycle();
        check("full valid drop", 32'(vld0), 0);
        check("full in_ready back", 32'(rdy0), 1);

        // Early close, then a fresh frame starting from zero.
        send(8'h07, 0); send(8'h00, 1);
        check("early parity", 32'(par0), 1);
        check("early words", 32'(ow0), 2);
        cycle();
        send(8'h01, 1);
        check("restart parity", 32'(par0), 1);
        check("restart words", 32'(ow0), 1);
        cycle();

        // Backpressure: result held, nothing consumed.
        out_ready = 1'b0;
        send(8'h01, 1);
        in_valid = 1'b1; in_data = 8'hFF;
        repeat (5) cycle();
        check("bp valid", 32'(vld0), 1);
        check("bp parity", 32'(par0), 1);
        check("bp words", 32'(ow0), 1);
        check("bp in_ready", 32'(rdy0), 0);
        out_ready = 1'b1;
        cycle();
        check("bp release valid", 32'(vld0), 0);
        check("bp release ready", 32'(rdy0), 1);
        in_valid = 1'b0;
        cycle();

        // Reset mid-frame discards the partial frame.
        send(8'h01, 0); send(8'h02, 0);
        rst = 1'b1;
        cycle();
        check("midrst valid", 32'(vld0), 0);
        check("midrst ready", 32'(rdy0), 0);
        rst = 1'b0;
        send(8'hFF, 0); send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
        check("midrst parity", 32'(par0), 1);
        check("midrst words", 32'(ow0), 4);
        cycle();

        // in_last coinciding with the word budget: exactly one result.
        send(8'h0F, 0); send(8'h0F, 0); send(8'h0F, 0); send(8'h0E, 1);
        check("lastcap parity", 32'(par0), 1);
        check("lastcap words", 32'(ow0), 4);
        cycle();
        check("lastcap single", 32'(vld0), 0);

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = $urandom_range(0, 1);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xor_parity_acc.md
Name: xor_parity_acc

Overview:
- Parametrised successor to the fixed 3-input XOR gate: reduces each WIDTH-bit input word to its XOR parity and accumulates parity across a frame of up to FRAME_LEN words.
- Emits one frame-parity result per frame over a valid/ready handshake.
- Used as a parity generator/checker stage between a word source (UART RX, switch sampler) and a consumer (LED/UART TX).

Parameters:
- WIDTH, 8, bits per input word (>=1).
- FRAME_LEN, 4, maximum words per frame (>=1); frame closes at this count if in_last not seen earlier.
- ODD, 0, 0 = even parity (out_parity = XOR of all bits); 1 = odd parity (result inverted).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  input word.
- in_last  input  1  current word is the final word of the frame.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts result.
- out_parity  output  1  frame parity (ODD applied).
- out_words  output  CW  words in the reported frame, CW = $clog2(FRAME_LEN+1).

Behaviour:
- Internal regs: acc (1b), cnt (CW), state in {ACC, DONE}.
- Reset (rst=1 at a clk edge): state=ACC, acc=0, cnt=0, out_valid=0, out_parity=0, out_words=0. in_ready is 0 while rst=1, else in_ready = (state==ACC).
- Accept = in_valid & in_ready. Word parity p = XOR-reduce(in_data).
- ACC, accept, not closing: acc<=acc^p, cnt<=cnt+1.
- Closing condition = accept & (in_last | cnt==FRAME_LEN-1). On close: out_parity<=acc^p^ODD, out_words<=cnt+1, out_valid<=1, acc<=0, cnt<=0, state<=DONE.
- Latency: out_valid high the cycle after the closing word is accepted.
- in_last together with cnt==FRAME_LEN-1: single close, out_words=FRAME_LEN.
- FRAME_LEN=1: every accepted word closes a frame, out_words=1.
- DONE: in_ready=0; out_parity/out_words held stable while out_valid=1 & !out_ready. On out_valid & out_ready: out_valid<=0, state<=ACC. No bypass: in_ready stays 0 in the handshake cycle and rises the next cycle. Max throughput is one frame per (words+1) cycles.
- in_valid without in_ready: word is not consumed, no state change. Source holds data.
- in_valid=0: no change to acc/cnt.
- Reset mid-frame or in DONE: partial frame and any pending result are discarded, with no out_valid pulse.
- out_words never exceeds FRAME_LEN. cnt never wraps.

Test Plan:
- WIDTH=8, FRAME_LEN=4, ODD=0, words 0x01,0x03,0x00,0x80 back-to-back, out_ready=1 -> one out_valid pulse the cycle after word 4, out_parity=0, out_words=4; in_ready low exactly 1 cycle.
- Same stimulus with ODD=1 -> out_parity=1, out_words=4.
- Early close: 0x07 then 0x00 with in_last=1 -> out_parity=1, out_words=2; next frame starts with acc=0 (0x01,in_last -> parity 1, words 1).
- Backpressure: after a close hold out_ready=0 for 5 cycles with in_valid=1, in_data=0xFF -> out_valid/out_parity/out_words stable, in_ready=0, no word consumed. Raise out_ready -> out_valid falls next cycle and in_ready rises.
- Reset mid-frame: accept 0x01,0x02, pulse rst 1 cycle, then 0xFF,0x01,0x00,0x00 -> out_valid=0 throughout reset, single result out_parity=1, out_words=4.
- in_last on 4th word (FRAME_LEN=4), words 0x0F,0x0F,0x0F,0x0E -> exactly one result, out_words=4, out_parity=1.
